ps2_ascii_decoder: RTL and testbench
====================================

PS2_ASCII_DECODER -- requirements
Module: ps2_ascii_decoder

Interface
REQ-001 SHALL have parameter none; all tables fixed (scan code set 2, US layout).
REQ-002 SHALL have port CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port iTrig  input  1  one-cycle strobe; raw scan code byte valid on iData.
REQ-005 SHALL have port iData  input  8  raw set-2 byte (make, 0xF0 break prefix, 0xE0 extend prefix).
REQ-006 SHALL have port oTrig  output  1  one-cycle strobe; ASCII character valid on oData.
REQ-007 SHALL have port oData  output  8  ASCII code; held until the next oTrig.
REQ-008 SHALL have port oShift  output  1  left or right shift currently held.
REQ-009 SHALL have port oCaps  output  1  caps-lock latch state.

Function
REQ-010 SHALL sample a byte only in cycles with iTrig=1, with no back-pressure; iTrig in consecutive cycles SHALL all be processed.
REQ-011 SHALL run a prefix FSM: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (0xE0 then 0xF0); any non-prefix byte returns to IDLE.
REQ-012 0xF0 in IDLE -> BRK; 0xE0 in IDLE -> EXT; 0xF0 in EXT -> EXT_BRK; a repeated prefix in the same state SHALL leave the state unchanged.
REQ-013 Byte in BRK SHALL be a break: 0x12 clears shL, 0x59 clears shR, 0x58 clears capsHeld; all other breaks SHALL produce no output.
REQ-014 Bytes in EXT/EXT_BRK SHALL be consumed without output or modifier change.
REQ-015 Make 0x12/0x59 in IDLE SHALL set shL/shR; oShift = shL|shR, updated the cycle after iTrig.
REQ-016 Mapped make code in IDLE SHALL produce oTrig exactly 2 cycles after its iTrig (cycle 1: registered lookup, cycle 2: strobe); unmapped codes SHALL produce nothing.
REQ-017 Map: letters a-z (1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A); digits 1-0 (16 1E 26 25 2E 36 3D 3E 46 45); 0x29->0x20; 0x5A->0x0D; 0x66->0x08.
REQ-018 Letters SHALL be uppercase iff (oShift XOR oCaps); digits SHALL map to !@#$%^&*() iff oShift; space/enter/backspace SHALL ignore modifiers.
REQ-019 Modifier state used SHALL be the state at the make code's iTrig cycle.
REQ-020 Typematic repeats of a mapped make SHALL each produce one oTrig.

Reset
REQ-021 RESET=1 at a clock edge SHALL set FSM=IDLE, shL=shR=0, caps=0, capsHeld=0, oTrig=0, oData=0x00, and discard any in-flight lookup.
REQ-022 RESET SHALL override a simultaneous iTrig; the first byte after RESET deasserts SHALL be decoded from IDLE.

Configuration
REQ-023 With PS2ASCII_CAPSLOCK_EN defined: make 0x58 in IDLE with capsHeld=0 SHALL toggle caps and set capsHeld; repeats while capsHeld=1 SHALL not toggle.
REQ-024 Without PS2ASCII_CAPSLOCK_EN: 0x58 SHALL be ignored, caps SHALL be constant 0, oCaps=0.

Structure
REQ-025 Package ps2_pkg SHALL hold prefix constants (0xE0, 0xF0), modifier codes (0x12, 0x59, 0x58) and the FSM state enum.
REQ-026 Combinational sub-module ps2_scan2ascii_rom SHALL take code, shift and caps and return ASCII plus a hit flag.

Verification
REQ-027 Reset, then 1C -> oTrig 2 cycles later, oData=0x61; oShift=0, oCaps=0.
REQ-028 12, 1C, F0 1C, F0 12, 1C -> 0x41 then 0x61; oShift 1 after first byte, 0 after F0 12.
REQ-029 With macro: 58, F0 58, 58 (repeat after release) -> oCaps toggles 1 then 0; 58, 58 (held) -> toggles once; 58, 12, 1C -> 0x61.
REQ-030 12, 16 -> 0x21; 45 with no shift -> 0x30; 29 with shift -> 0x20.
REQ-031 E0 75, E0 F0 75, 1C -> exactly one oTrig (0x61), no output for extended bytes.
REQ-032 F0, RESET pulse, 1C -> 0x61 emitted (BRK state discarded); iTrig on RESET cycle -> no output.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and prefix FSM state type for the PS/2 set-2 to ASCII decoder
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;
    localparam logic [7:0] CODE_CAPS    = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_ascii_decoder_if.sv
// rtl/ps2_ascii_decoder_if.sv - scan byte input strobe and ASCII/modifier outputs of the decoder
interface ps2_ascii_decoder_if;
    logic       iTrig;
    logic [7:0] iData;
    logic       oTrig;
    logic [7:0] oData;
    logic       oShift;
    logic       oCaps;

    modport master (output iTrig, iData, input oTrig, oData, oShift, oCaps);
    modport slave  (input iTrig, iData, output oTrig, oData, oShift, oCaps);
endinterface

// File: rtl/ps2_scan2ascii_rom.sv
// rtl/ps2_scan2ascii_rom.sv - combinational set-2 make code to US ASCII lookup with shift/caps
module ps2_scan2ascii_rom (
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] ascii_o,
    output logic       hit_o
);

    logic [7:0] letter;

    always_comb begin
        ascii_o = 8'h00;
        hit_o   = 1'b0;
        letter  = 8'h00;
        case (code_i)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h16: begin hit_o = 1'b1; ascii_o = shift_i ? "!" : "1"; end
            8'h1E: begin hit_o = 1'b1; ascii_o = shift_i ? "@" : "2"; end
            8'h26: begin hit_o = 1'b1; ascii_o = shift_i ? "#" : "3"; end
            8'h25: begin hit_o = 1'b1; ascii_o = shift_i ? "$" : "4"; end
            8'h2E: begin hit_o = 1'b1; ascii_o = shift_i ? "%" : "5"; end
            8'h36: begin hit_o = 1'b1; ascii_o = shift_i ? "^" : "6"; end
            8'h3D: begin hit_o = 1'b1; ascii_o = shift_i ? "&" : "7"; end
            8'h3E: begin hit_o = 1'b1; ascii_o = shift_i ? "*" : "8"; end
            8'h46: begin hit_o = 1'b1; ascii_o = shift_i ? "(" : "9"; end
            8'h45: begin hit_o = 1'b1; ascii_o = shift_i ? ")" : "0"; end
            8'h29: begin hit_o = 1'b1; ascii_o = 8'h20; end
            8'h5A: begin hit_o = 1'b1; ascii_o = 8'h0D; end
            8'h66: begin hit_o = 1'b1; ascii_o = 8'h08; end
            default: ;
        endcase
        // Shift and caps cancel each other for letters only
        if (letter != 8'h00) begin
            hit_o   = 1'b1;
            ascii_o = (shift_i ^ caps_i) ? (letter - 8'h20) : letter;
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// rtl/ps2_ascii_decoder.sv - PS/2 set-2 byte stream to ASCII decoder; caps lock enabled by PS2ASCII_CAPSLOCK_EN
module ps2_ascii_decoder
    import ps2_pkg::*;
(
    input  logic                CLOCK,
    input  logic                RESET,
    ps2_ascii_decoder_if.slave  bus
);

    ps2_state_e state_q, state_d;
    logic       sh_l_q, sh_l_d;
    logic       sh_r_q, sh_r_d;
    logic       caps_q, caps_d;
    logic       caps_held_q, caps_held_d;
    logic       hit_q, hit_d;
    logic [7:0] char_q, char_d;
    logic       otrig_q;
    logic [7:0] odata_q;
    logic [7:0] rom_ascii;
    logic       rom_hit;
    logic       is_prefix;

    ps2_scan2ascii_rom u_rom (
        .code_i  (bus.iData),
        .shift_i (sh_l_q | sh_r_q),
        .caps_i  (caps_q),
        .ascii_o (rom_ascii),
        .hit_o   (rom_hit)
    );

    assign is_prefix = (bus.iData == PREFIX_EXT) || (bus.iData == PREFIX_BRK);

    always_comb begin
        state_d     = state_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        hit_d       = 1'b0;
        char_d      = char_q;
        if (bus.iTrig) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iData == PREFIX_BRK)        state_d = ST_BRK;
                    else if (bus.iData == PREFIX_EXT)   state_d = ST_EXT;
                    else if (bus.iData == CODE_SHIFT_L) sh_l_d  = 1'b1;
                    else if (bus.iData == CODE_SHIFT_R) sh_r_d  = 1'b1;
                    else if (bus.iData == CODE_CAPS) begin
`ifdef PS2ASCII_CAPSLOCK_EN
                        if (!caps_held_q) begin
                            caps_d      = ~caps_q;
                            caps_held_d = 1'b1;
                        end
`endif
                    end else begin
                        hit_d  = rom_hit;
                        char_d = rom_ascii;
                    end
                end
                ST_EXT: begin
                    if (bus.iData == PREFIX_BRK)   state_d = ST_EXT_BRK;
                    else if (!is_prefix)           state_d = ST_IDLE;
                end
                ST_BRK: begin
                    if (!is_prefix) begin
                        state_d = ST_IDLE;
                        if (bus.iData == CODE_SHIFT_L) sh_l_d      = 1'b0;
                        if (bus.iData == CODE_SHIFT_R) sh_r_d      = 1'b0;
                        if (bus.iData == CODE_CAPS)    caps_held_d = 1'b0;
                    end
                end
                ST_EXT_BRK: begin
                    if (!is_prefix) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            sh_l_q      <= 1'b0;
            sh_r_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            hit_q       <= 1'b0;
            char_q      <= 8'h00;
            otrig_q     <= 1'b0;
            odata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            hit_q       <= hit_d;
            char_q      <= char_d;
            otrig_q     <= hit_q;
            if (hit_q) odata_q <= char_q;
        end
    end

    assign bus.oTrig  = otrig_q;
    assign bus.oData  = odata_q;
    assign bus.oShift = sh_l_q | sh_r_q;
    assign bus.oCaps  = caps_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb/tb_ps2_ascii_decoder.sv - scoreboard bench for the PS/2 to ASCII decoder
module tb_ps2_ascii_decoder;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [7:0] last_data = 8'h00;

    ps2_ascii_decoder_if bus ();

    ps2_ascii_decoder dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.oTrig === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_otrig", {31'b0, bus.oTrig}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("odata", {24'b0, bus.oData}, {24'b0, e.data});
                check("latency", cyc, e.cyc);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; the byte is sampled at the next edge.
    task automatic send(input logic [7:0] b, input bit exp_v, input logic [7:0] exp_d);
        exp_t e;
        bus.iTrig = 1'b1;
        bus.iData = b;
        if (exp_v) begin
            e.data = exp_d;
            e.cyc  = cyc + 2;
            sb.push_back(e);
            last_data = exp_d;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.iTrig = 1'b0;
        bus.iData = 8'h00;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        idle(1);
        while (sb.size() != 0 && budget > 0) begin idle(1); budget--; end
        check("drain_pending", sb.size(), 0);
        idle(3);
    endtask

    logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                 8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                 8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digits  [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    logic [7:0] dig_pl  [10] = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30};
    logic [7:0] dig_sh  [10] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iTrig = 1'b0;
        bus.iData = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_otrig", {31'b0, bus.oTrig}, 0);
        check("rst_odata", {24'b0, bus.oData}, 0);
        check("rst_oshift", {31'b0, bus.oShift}, 0);
        check("rst_ocaps", {31'b0, bus.oCaps}, 0);
        rst = 1'b0;

        send(8'h1C, 1, 8'h61);
        check("plain_oshift", {31'b0, bus.oShift}, 0);
        check("plain_ocaps", {31'b0, bus.oCaps}, 0);
        drain();
        check("odata_held", {24'b0, bus.oData}, 8'h61);

        send(8'h12, 0, 0);
        check("shift_set", {31'b0, bus.oShift}, 1);
        send(8'h1C, 1, 8'h41);
        send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        send(8'hF0, 0, 0); send(8'h12, 0, 0);
        check("shift_clr", {31'b0, bus.oShift}, 0);
        send(8'h1C, 1, 8'h61);
        drain();

        send(8'h59, 0, 0);
        check("shift_r_set", {31'b0, bus.oShift}, 1);
        send(8'h16, 1, 8'h21);
        send(8'hF0, 0, 0); send(8'h59, 0, 0);
        send(8'h45, 1, 8'h30);
        send(8'h12, 0, 0);
        send(8'h29, 1, 8'h20);
        send(8'h5A, 1, 8'h0D);
        send(8'h66, 1, 8'h08);
        send(8'hF0, 0, 0); send(8'h12, 0, 0);
        drain();

        send(8'hE0, 0, 0); send(8'h75, 0, 0);
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
        send(8'hE0, 0, 0); send(8'hE0, 0, 0); send(8'h1C, 0, 0);
        send(8'hF0, 0, 0); send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        send(8'h76, 0, 0);
        send(8'h1C, 1, 8'h61);
        send(8'h1C, 1, 8'h61);
        send(8'h1C, 1, 8'h61);
        drain();

        for (int i = 0; i < 26; i++) send(letters[i], 1, 8'(8'h61 + i));
        send(8'h12, 0, 0);
        for (int i = 0; i < 26; i++) send(letters[i], 1, 8'(8'h41 + i));
        for (int i = 0; i < 10; i++) send(digits[i], 1, dig_sh[i]);
        send(8'hF0, 0, 0); send(8'h12, 0, 0);
        for (int i = 0; i < 10; i++) send(digits[i], 1, dig_pl[i]);
        drain();

`ifdef PS2ASCII_CAPSLOCK_EN
        send(8'h58, 0, 0);
        check("caps_on", {31'b0, bus.oCaps}, 1);
        send(8'h1C, 1, 8'h41);
        send(8'hF0, 0, 0); send(8'h58, 0, 0);
        send(8'h58, 0, 0);
        check("caps_off", {31'b0, bus.oCaps}, 0);
        send(8'h58, 0, 0);
        check("caps_held_nochg", {31'b0, bus.oCaps}, 0);
        send(8'hF0, 0, 0); send(8'h58, 0, 0);
        send(8'h58, 0, 0);
        send(8'h58, 0, 0);
        check("caps_once", {31'b0, bus.oCaps}, 1);
        send(8'h12, 0, 0);
        send(8'h1C, 1, 8'h61);
        send(8'hF0, 0, 0); send(8'h12, 0, 0);
        send(8'hF0, 0, 0); send(8'h58, 0, 0);
        send(8'h58, 0, 0);
        check("caps_final_off", {31'b0, bus.oCaps}, 0);
        send(8'hF0, 0, 0); send(8'h58, 0, 0);
`else
        send(8'h58, 0, 0);
        check("caps_disabled", {31'b0, bus.oCaps}, 0);
        send(8'h1C, 1, 8'h61);
        send(8'hF0, 0, 0); send(8'h58, 0, 0);
        send(8'h58, 0, 0);
        send(8'h12, 0, 0);
        send(8'h1C, 1, 8'h41);
        send(8'hF0, 0, 0); send(8'h12, 0, 0);
        send(8'hF0, 0, 0); send(8'h58, 0, 0);
        check("caps_disabled_end", {31'b0, bus.oCaps}, 0);
`endif
        drain();

        send(8'hF0, 0, 0);
        rst = 1'b1;
        send(8'h1C, 0, 0);
        rst = 1'b0;
        check("rst_trig_otrig", {31'b0, bus.oTrig}, 0);
        check("rst_trig_odata", {24'b0, bus.oData}, 0);
        idle(3);
        send(8'h1C, 1, 8'h61);
        drain();

        send(8'h12, 0, 0);
        send(8'h1C, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_clr_shift", {31'b0, bus.oShift}, 0);
        idle(4);
        send(8'h2B, 1, 8'h66);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
